// File: rtl/mac_div.sv
// mac_div -- sequential restoring divider, companion to the MAC.
// Divides a DW-bit accumulated sum by a VW-bit count/scale factor and
// produces quotient and remainder, one quotient bit per clock, MSB first.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset (0 = reset)
//   start        request, sampled only when not busy (IDLE or DONE)
//   dividend     DW-bit unsigned dividend, captured on accepted start
//   divisor      VW-bit unsigned divisor, captured on accepted start
//   busy         high while a division is in progress
//   done         one-cycle pulse when results become valid
//   quotient     DW-bit quotient, held until the next result
//   remainder    VW-bit remainder, held until the next result
//   div_by_zero  set with done when the divisor was 0, held with the results
module mac_div #(
    parameter int unsigned DW = 36,
    parameter int unsigned VW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t         state_q;
    logic [DW-1:0]  work_q;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [DW-1:0]  work_d;
    logic [VW-1:0]  rem_q;       // partial remainder; always < divisor between steps
    logic [VW-1:0]  rem_d;
    logic [VW:0]    rem_shift;   // VW+1 bits so the compare never overflows
    logic [VW-1:0]  dvs_q;
    logic [CW-1:0]  cnt_q;
    logic           qbit;

    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] quotient_q;
    logic [VW-1:0] remainder_q;
    logic          dbz_q;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem_q, work_q[DW-1]};
        qbit      = (rem_shift >= {1'b0, dvs_q});
        rem_d     = qbit ? VW'(rem_shift - {1'b0, dvs_q}) : rem_shift[VW-1:0];
        work_d    = {work_q[DW-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (start) begin
                        if (divisor == '0) begin
                            // Divide-by-zero short-circuits straight to DONE.
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= '0;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= DIV;
                            work_q  <= dividend;
                            dvs_q   <= divisor;
                            rem_q   <= '0;
                            cnt_q   <= CW'(DW - 1);
                            busy_q  <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        // Final step: publish results straight from the step logic.
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= work_d;
                        remainder_q <= rem_d;
                        dbz_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mac_div.sv
// tb_mac_div -- self-checking bench for mac_div.
// Directed and random divisions are compared against plain integer
// division (/ and %) computed in the bench; latency, busy length,
// done pulse, ignored start, back-to-back start and mid-division reset
// are checked with immediate assertions.
module tb_mac_div;

    localparam int DW = 36;
    localparam int VW = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    mac_div #(.DW(DW), .VW(VW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer division.
    task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         output logic [DW-1:0] eq, output logic [VW-1:0] er, output logic ez);
        if (b == 0) begin
            eq = '1;
            er = '0;
            ez = 1'b1;
        end else begin
            eq = a / DW'(b);
            er = VW'(a % DW'(b));
            ez = 1'b0;
        end
    endtask

    // Waits for done after the acceptance edge; returns edges counted after it
    // (0 = done already visible after the acceptance edge, -1 = timed out).
    task automatic wait_done(output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        if (done) lat = 0;
        else if (busy) busy_n = 1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k;
            else if (busy) busy_n++;
        end
    endtask

    task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b, input string tag);
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic          ez;
        int            lat;
        int            busy_n;
        model(a, b, eq, er, ez);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        fork
            begin
                @(negedge clk);
                start = 1'b0;
            end
        join_none
        wait_done(lat, busy_n);
        check({tag, ".latency"}, 64'(lat), (b == 0) ? 64'd0 : 64'(DW));
        check({tag, ".busy_cycles"}, 64'(busy_n), (b == 0) ? 64'd0 : 64'(DW));
        check({tag, ".quotient"}, 64'(quotient), 64'(eq));
        check({tag, ".remainder"}, 64'(remainder), 64'(er));
        check({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(ez));
        @(posedge clk); #1;
        check({tag, ".done_single"}, 64'(done), 64'd0);
        check({tag, ".quotient_hold"}, 64'(quotient), 64'(eq));
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [VW-1:0] rb;
        int            lat;
        int            busy_n;
        int            done_seen;

        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.quotient", 64'(quotient), 64'd0);
        check("reset.remainder", 64'(remainder), 64'd0);
        check("reset.dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        run_div(36'd240, 16'd20, "d240_20");
        run_div(36'd760, 16'd3, "d760_3");
        run_div({DW{1'b1}}, 16'hFFFF, "dmax_ffff");
        run_div({DW{1'b1}}, 16'd1, "dmax_1");
        run_div(36'd5, 16'd9, "d5_9");
        run_div(36'd100, 16'd0, "d100_0");
        run_div(36'd100, 16'd7, "d100_7");

        // Start during DIV is ignored; then start held in DONE
        @(negedge clk);
        dividend = 36'd240;
        divisor  = 16'd20;
        start    = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        dividend = 36'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dividend = 36'd777;
        divisor  = 16'd0;
        wait_done(lat, busy_n);
        // 10 edges already elapsed before the wait began
        check("ignore.latency", 64'(lat + 10), 64'(DW));
        check("ignore.quotient", 64'(quotient), 64'd12);
        check("ignore.remainder", 64'(remainder), 64'd0);
        @(negedge clk);
        dividend = 36'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(posedge clk); #1;
        check("b2b.done_clear", 64'(done), 64'd0);
        check("b2b.busy", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, busy_n);
        check("b2b.latency", 64'(lat + 1), 64'(DW + 1));
        check("b2b.quotient", 64'(quotient), 64'd10);
        check("b2b.remainder", 64'(remainder), 64'd0);

        // Reset in the middle of a division
        @(negedge clk);
        dividend = 36'd240;
        divisor  = 16'd20;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        check("midrst.quotient", 64'(quotient), 64'd0);
        check("midrst.remainder", 64'(remainder), 64'd0);
        check("midrst.dbz", 64'(div_by_zero), 64'd0);
        done_seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("midrst.no_done", 64'(done_seen), 64'd0);
        run_div(36'd240, 16'd20, "after_rst");

        // Random divisions against the model
        for (int i = 0; i < 20; i++) begin
            ra = {4'($urandom), 32'($urandom)};
            rb = 16'($urandom) >> $urandom_range(0, 15);
            if (i % 3 == 0) ra = ra >> $urandom_range(0, 35);
            run_div(ra, rb, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
